// File: rtl/walk_register_if.sv
// Signal bundle between the traffic controller and the walk request latch.
// The controller drives the button level and the served-clear; the latch returns the pending flag.
interface walk_register_if;
    // Level semantics, no handshake: the button is a level sampled on every rising clk,
    // walkRegister_reset is a one-cycle clear strobe, and walkRegister_status is a registered level.
    logic walk_Btn_Pressed;
    logic walkRegister_reset;
    logic walkRegister_status;

    modport master (
        output walk_Btn_Pressed,
        output walkRegister_reset,
        input  walkRegister_status
    );

    modport slave (
        input  walk_Btn_Pressed,
        input  walkRegister_reset,
        output walkRegister_status
    );
endinterface

// File: rtl/walk_register.sv
// Sticky pedestrian walk request: set by a sampled button press, held until the
// controller clears it or the system resets. Clears always beat a press.
module walk_register (
    input  logic           clk,
    input  logic           sys_reset,
    walk_register_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The served-clear outranks a press on the same edge, so a held button re-arms
    // only on the first edge after the clear drops.
    always_comb begin
        state_next = state;
        if (bus.walkRegister_reset) begin
            state_next = IDLE;
        end else if (bus.walk_Btn_Pressed) begin
            state_next = PENDING;
        end
    end

    // The state register is the pending flag; no input reaches the output combinationally.
    assign bus.walkRegister_status = (state == PENDING);

endmodule

// File: tb/tb_walk_register.sv
// Directed and randomized check of the walk request latch against a small priority model.
module tb_walk_register;

  logic clk;
  logic sys_reset;
  int   checks;
  int   failures;

  logic  exp_q[$];
  string tag_q[$];
  logic  model;

  walk_register_if bus();

  walk_register dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  // clock/reset block: rising edges at 50, 150, 250 ... ns
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check_out();
    logic  e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty got=%0d exp=1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (bus.walkRegister_status === e) else begin
        failures++;
        $error("FAIL %s got=%b exp=%b", t, bus.walkRegister_status, e);
      end
    end
  endtask

  // driver: called at a falling edge, applies inputs over the next rising edge, samples 10 ns after it
  task automatic cycle(input logic b, input logic w, input logic s, input logic e, input string t);
    bus.walk_Btn_Pressed   = b;
    bus.walkRegister_reset = w;
    sys_reset              = s;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #10;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sys_reset              = 1'b1;
    bus.walk_Btn_Pressed   = 1'b0;
    bus.walkRegister_reset = 1'b0;
    @(negedge clk);

    cycle(0, 0, 1, 0, "reset");
    cycle(1, 0, 0, 1, "press_set");
    cycle(0, 0, 0, 1, "hold_after_release_1");
    cycle(0, 0, 0, 1, "hold_after_release_2");
    cycle(1, 0, 0, 1, "repeat_press_no_effect");
    cycle(1, 1, 0, 0, "clear_beats_press");
    cycle(1, 0, 0, 1, "held_button_rearms");
    cycle(1, 1, 0, 0, "clear_again");
    cycle(0, 0, 0, 0, "stay_clear");
    cycle(1, 0, 0, 1, "rearm_single_edge");
    cycle(0, 0, 0, 1, "rearm_held");
    cycle(1, 0, 1, 0, "sys_reset_mid_request");
    cycle(0, 0, 0, 0, "stay_after_sys_reset");

    // glitch: button pulse entirely between two rising edges
    #10 bus.walk_Btn_Pressed = 1'b1;
    #30 bus.walk_Btn_Pressed = 1'b0;
    @(negedge clk);
    cycle(0, 0, 0, 0, "glitch_rejected");

    cycle(1, 0, 0, 1, "set_before_all_clear");
    cycle(1, 1, 1, 0, "all_asserted_clear");
    cycle(0, 1, 0, 0, "clear_while_idle");
    cycle(0, 0, 1, 0, "sys_reset_while_idle");

    model = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic b, w, s;
      b = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) == 0);
      if (s)      model = 1'b0;
      else if (w) model = 1'b0;
      else if (b) model = 1'b1;
      cycle(b, w, s, model, $sformatf("random_%0d", i));
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
